// File: rtl/tea_pkg.sv
// Shared definitions for the TEA job scheduler: word size, cipher constants,
// request modes, FSM state encodings and small helpers.
package tea_pkg;

   localparam int TEA_WORD_SIZE    = 16;
   localparam int TEA_ROUND_NUMBER = 32;
   localparam logic [TEA_WORD_SIZE-1:0] TEA_DELTA = 16'h9E37;

   localparam logic MODE_CIPHER   = 1'b0;
   localparam logic MODE_DECIPHER = 1'b1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   // Round-robin successor of a requester index.
   function automatic int rr_next(input int idx, input int num);
      return (idx + 1 >= num) ? 0 : idx + 1;
   endfunction

   // Starting sum for the decipher rounds (delta times round count, wrapped).
   function automatic logic [TEA_WORD_SIZE-1:0] tea_decipher_sum_init();
      return TEA_WORD_SIZE'(TEA_DELTA * TEA_ROUND_NUMBER);
   endfunction

endpackage

// File: rtl/tea_job_scheduler_if.sv
// Requester-side request/response channels of the TEA job scheduler.
// Signal names are from the scheduler's point of view (i = into scheduler).
interface tea_job_scheduler_if #(
   parameter int WORD_SIZE = 16,
   parameter int NUM_REQ   = 2
);

   logic [NUM_REQ-1:0]             iReqValid;
   logic [NUM_REQ-1:0]             oReqReady;
   logic [NUM_REQ-1:0]             iReqMode;
   logic [NUM_REQ*2*WORD_SIZE-1:0] iReqData;
   logic [NUM_REQ-1:0]             oRspValid;
   logic [NUM_REQ-1:0]             iRspReady;
   logic [2*WORD_SIZE-1:0]         oRspData;
   logic                           oRspError;

   modport master (
      output iReqValid, iReqMode, iReqData, iRspReady,
      input  oReqReady, oRspValid, oRspData, oRspError
   );

   modport slave (
      input  iReqValid, iReqMode, iReqData, iRspReady,
      output oReqReady, oRspValid, oRspData, oRspError
   );

endinterface

// File: rtl/tea_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or after ptr,
// wrapping, and returns it as a one-hot grant plus its index.
module tea_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   idx,
   output logic               found
);

   function automatic int slot(input logic [PTR_W-1:0] p, input int off);
      return (int'(p) + off) % NUM_REQ;
   endfunction

   always_comb begin
      // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[slot(ptr, i)]) begin
            found              = 1'b1;
            grant[slot(ptr, i)] = 1'b1;
            idx                = PTR_W'(slot(ptr, i));
         end
      end
   end

endmodule

// File: rtl/tea_job_scheduler.sv
// Sequences the shared TEA cipher/decipher engines for NUM_REQ requesters:
// round-robin grant, one job in flight, timeout-guarded wait, valid/ready response.
module tea_job_scheduler
   import tea_pkg::*;
#(
   parameter int WORD_SIZE      = TEA_WORD_SIZE,
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 512
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   iKeyLoad,
   input  logic [4*WORD_SIZE-1:0] iKey,
   tea_job_scheduler_if.slave     bus,
   output logic                   oBusy,
   output logic                   oStartCipher,
   output logic                   oStartDecipher,
   output logic [WORD_SIZE-1:0]   oV0,
   output logic [WORD_SIZE-1:0]   oV1,
   output logic [WORD_SIZE-1:0]   oK0,
   output logic [WORD_SIZE-1:0]   oK1,
   output logic [WORD_SIZE-1:0]   oK2,
   output logic [WORD_SIZE-1:0]   oK3,
   input  logic [WORD_SIZE-1:0]   iC0,
   input  logic [WORD_SIZE-1:0]   iC1,
   input  logic                   iDoneCipher,
   input  logic [WORD_SIZE-1:0]   iP0,
   input  logic [WORD_SIZE-1:0]   iP1,
   input  logic                   iDoneDecipher
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int DW    = 2 * WORD_SIZE;

   logic [1:0]             state;
   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       gidx_q;
   logic [NUM_REQ-1:0]     grant_q;
   logic                   key_valid;
   logic [4*WORD_SIZE-1:0] key_q;
   logic [DW-1:0]          opnd_q;
   logic [DW-1:0]          res_q;
   logic                   mode_q;
   logic                   err_q;
   logic [CNT_W-1:0]       cnt_q;

   logic [NUM_REQ-1:0]     arb_grant;
   logic [PTR_W-1:0]       arb_idx;
   logic                   arb_found;
   logic                   grant_fire;
   logic                   done_sel;
   logic                   rsp_fire;

   tea_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .req   (bus.iReqValid),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .found (arb_found)
   );

   // A key load takes priority over granting, so a job never starts on a stale key.
   assign grant_fire = (state == ST_IDLE) && !iKeyLoad && key_valid && arb_found;
   assign done_sel   = (mode_q == MODE_DECIPHER) ? iDoneDecipher : iDoneCipher;
   assign rsp_fire   = (state == ST_RESP) && |(bus.iRspReady & grant_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         gidx_q    <= '0;
         grant_q   <= '0;
         key_valid <= 1'b0;
         key_q     <= '0;
         opnd_q    <= '0;
         res_q     <= '0;
         mode_q    <= MODE_CIPHER;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments here, so every register samples pre-edge values regardless of statement order.
         case (state)
            ST_IDLE: begin
               if (iKeyLoad) begin
                  key_q     <= iKey;
                  key_valid <= 1'b1;
               end else if (grant_fire) begin
                  opnd_q  <= bus.iReqData[arb_idx*DW +: DW];
                  mode_q  <= bus.iReqMode[arb_idx];
                  gidx_q  <= arb_idx;
                  grant_q <= arb_grant;
                  state   <= ST_START;
               end
            end
            ST_START: begin
               cnt_q <= CNT_W'(TIMEOUT_CYCLES);
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               // Done is checked first so it wins over an expiring counter.
               if (done_sel) begin
                  res_q <= (mode_q == MODE_DECIPHER) ? {iP1, iP0} : {iC1, iC0};
                  err_q <= 1'b0;
                  state <= ST_RESP;
               end else if (cnt_q <= CNT_W'(1)) begin
                  cnt_q <= '0;
                  res_q <= '0;
                  err_q <= 1'b1;
                  state <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_RESP: begin
               if (rsp_fire) begin
                  rr_ptr <= PTR_W'(rr_next(int'(gidx_q), NUM_REQ));
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.oReqReady = grant_fire ? arb_grant : '0;
   assign bus.oRspValid = (state == ST_RESP) ? grant_q : '0;
   assign bus.oRspData  = res_q;
   assign bus.oRspError = err_q;

   assign oBusy          = (state != ST_IDLE);
   assign oStartCipher   = (state == ST_START) && (mode_q == MODE_CIPHER);
   assign oStartDecipher = (state == ST_START) && (mode_q == MODE_DECIPHER);
   assign {oV1, oV0}     = opnd_q;
   assign {oK3, oK2, oK1, oK0} = key_q;

endmodule

// File: tb/tb_tea_job_scheduler.sv
// Directed bench for tea_job_scheduler: key gating, cipher/decipher jobs,
// round-robin order, timeout, done-at-deadline and mid-job reset.
module tb_tea_job_scheduler;

   localparam int W  = 16;
   localparam int N  = 2;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          iKeyLoad;
   logic [4*W-1:0] iKey;
   logic          oBusy, oStartCipher, oStartDecipher;
   logic [W-1:0]  oV0, oV1, oK0, oK1, oK2, oK3;
   logic [W-1:0]  iC0, iC1, iP0, iP1;
   logic          iDoneCipher, iDoneDecipher;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   tea_job_scheduler_if #(.WORD_SIZE(W), .NUM_REQ(N)) bus ();

   tea_job_scheduler #(
      .WORD_SIZE      (W),
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .iKeyLoad       (iKeyLoad),
      .iKey           (iKey),
      .bus            (bus),
      .oBusy          (oBusy),
      .oStartCipher   (oStartCipher),
      .oStartDecipher (oStartDecipher),
      .oV0            (oV0),
      .oV1            (oV1),
      .oK0            (oK0),
      .oK1            (oK1),
      .oK2            (oK2),
      .oK3            (oK3),
      .iC0            (iC0),
      .iC1            (iC1),
      .iDoneCipher    (iDoneCipher),
      .iP0            (iP0),
      .iP1            (iP1),
      .iDoneDecipher  (iDoneDecipher)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic mode, input logic [2*W-1:0] data);
      bus.iReqMode[r]            = mode;
      bus.iReqData[r*2*W +: 2*W] = data;
   endtask

   // Engine stand-in: cipher {V1+K2, V0+K0}, decipher {V1-K2, V0-K0}.
   // With mute set the selected engine stays silent and the other one pulses done.
   task automatic run_job(input string tag, input logic [N-1:0] g, input logic mode,
                          input int lat, input bit mute, input logic [2*W-1:0] exp_data,
                          input logic exp_err, input bit keep);
      #1;
      check({tag, ".ready"}, bus.oReqReady, g);
      step();
      check({tag, ".start_c"}, oStartCipher, (mode == 1'b0));
      check({tag, ".start_d"}, oStartDecipher, (mode == 1'b1));
      check({tag, ".busy"}, oBusy, 1'b1);
      if (!keep) bus.iReqValid = '0;
      for (int k = 1; k <= lat; k++) begin
         step();
         check({tag, ".wait"}, {oStartCipher, oStartDecipher, bus.oRspValid}, 4'b0);
         if (k == lat) begin
            if (mode == 1'b0 && !mute) begin
               iC0 = oV0 + oK0;  iC1 = oV1 + oK2;  iDoneCipher = 1'b1;
            end else if (mode == 1'b1 && !mute) begin
               iP0 = oV0 - oK0;  iP1 = oV1 - oK2;  iDoneDecipher = 1'b1;
            end else if (mode == 1'b0) begin
               iP0 = 16'hBEEF;   iP1 = 16'hDEAD;   iDoneDecipher = 1'b1;
            end else begin
               iC0 = 16'hBEEF;   iC1 = 16'hDEAD;   iDoneCipher = 1'b1;
            end
         end
      end
      step();
      iDoneCipher   = 1'b0;
      iDoneDecipher = 1'b0;
      check({tag, ".rsp_valid"}, bus.oRspValid, g);
      check({tag, ".rsp_data"}, bus.oRspData, exp_data);
      check({tag, ".rsp_err"}, bus.oRspError, exp_err);
      step();
      check({tag, ".hold_valid"}, bus.oRspValid, g);
      check({tag, ".hold_data"}, bus.oRspData, exp_data);
      bus.iRspReady = g;
      #1;
      check({tag, ".no_same_cycle_grant"}, bus.oReqReady, '0);
      step();
      bus.iRspReady = '0;
      check({tag, ".idle"}, {oBusy, bus.oRspValid}, 3'b0);
   endtask

   initial begin
      iKeyLoad = 1'b0;  iKey = '0;
      iC0 = '0;  iC1 = '0;  iP0 = '0;  iP1 = '0;
      iDoneCipher = 1'b0;  iDoneDecipher = 1'b0;
      bus.iReqValid = '0;  bus.iReqMode = '0;  bus.iReqData = '0;  bus.iRspReady = '0;

      // Reset state
      step();
      step();
      check("rst.busy", oBusy, 1'b0);
      check("rst.start", {oStartCipher, oStartDecipher}, 2'b0);
      check("rst.ready", bus.oReqReady, '0);
      check("rst.rsp", {bus.oRspValid, bus.oRspError, bus.oRspData}, '0);
      check("rst.key", {oK3, oK2, oK1, oK0}, '0);
      check("rst.opnd", {oV1, oV0}, '0);
      rst = 1'b1;

      // No key loaded: requests are never accepted
      set_req(0, 1'b0, 32'h5678_1234);
      bus.iReqValid = 2'b01;
      for (int i = 0; i < 20; i++) begin
         step();
         check("nokey", {bus.oReqReady, oStartCipher, oStartDecipher, oBusy}, 5'b0);
      end

      // Key load in the same cycle as a pending request: grant waits one cycle
      iKeyLoad = 1'b1;
      iKey     = 64'h0123_4567_89AB_CDEF;
      #1;
      check("keyload.ready", bus.oReqReady, '0);
      step();
      iKeyLoad = 1'b0;
      check("keyload.k0", oK0, 16'hCDEF);
      check("keyload.k3", oK3, 16'h0123);
      run_job("cipher0", 2'b01, 1'b0, 3, 1'b0, 32'h9BDF_E023, 1'b0, 1'b0);

      // Ciphertext deciphered by requester 1
      set_req(1, 1'b1, 32'h9BDF_E023);
      bus.iReqValid = 2'b10;
      run_job("decipher1", 2'b10, 1'b1, 3, 1'b0, 32'h5678_1234, 1'b0, 1'b0);

      // Both requesters always valid: order 0,1,0,1
      set_req(0, 1'b0, 32'h5678_1234);
      set_req(1, 1'b0, 32'h1111_2222);
      bus.iReqValid = 2'b11;
      run_job("rr0", 2'b01, 1'b0, 3, 1'b0, 32'h9BDF_E023, 1'b0, 1'b1);
      run_job("rr1", 2'b10, 1'b0, 3, 1'b0, 32'h5678_F011, 1'b0, 1'b1);
      run_job("rr2", 2'b01, 1'b0, 3, 1'b0, 32'h9BDF_E023, 1'b0, 1'b1);
      run_job("rr3", 2'b10, 1'b0, 3, 1'b0, 32'h5678_F011, 1'b0, 1'b0);

      // Done arriving on the last counter cycle still wins
      bus.iReqValid = 2'b01;
      run_job("deadline", 2'b01, 1'b0, TO, 1'b0, 32'h9BDF_E023, 1'b0, 1'b0);

      // Silent cipher engine (decipher done is a decoy): timeout at start+9
      bus.iReqValid = 2'b01;
      run_job("timeout", 2'b01, 1'b0, TO, 1'b1, 32'h0, 1'b1, 1'b0);

      // Reset during WAIT, then a late engine done
      bus.iReqValid = 2'b01;
      #1;
      check("midrst.ready", bus.oReqReady, 2'b01);
      step();
      step();
      bus.iReqValid = '0;
      rst = 1'b0;
      #1;
      check("midrst.busy", oBusy, 1'b0);
      check("midrst.state_regs", {oK0, oV0, oStartCipher}, '0);
      step();
      rst = 1'b1;
      step();
      iC0 = 16'hAAAA;  iC1 = 16'h5555;  iDoneCipher = 1'b1;
      step();
      iDoneCipher = 1'b0;
      bus.iReqValid = 2'b01;
      for (int i = 0; i < 4; i++) begin
         step();
         check("midrst.quiet", {bus.oRspValid, bus.oReqReady, oBusy}, 5'b0);
      end
      iKeyLoad = 1'b1;
      #1;
      check("reload.ready", bus.oReqReady, '0);
      step();
      iKeyLoad = 1'b0;
      run_job("reload", 2'b01, 1'b0, 3, 1'b0, 32'h9BDF_E023, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
